// File: rtl/mac_result_quantizer.sv
`default_nettype none
// ============================================================================
// Module   : mac_result_quantizer
// Brief    : Rounds, shifts and saturates MAC accumulator samples, queues the
//            results in a small FIFO drained over valid/ready, sticky status.
// Revision : 1.0 - initial release
// ============================================================================
module mac_result_quantizer #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 8,
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,
  input  logic [ACC_W-1:0] acc_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fifo_full,
  output logic             sat_flag,
  output logic [7:0]       drop_cnt,
  input  logic             clr_flags
);

  localparam int               c_aw      = $clog2(DEPTH);
  localparam logic [ACC_W:0]   c_half    = (ACC_W+1)'(1) << (SHIFT-1);
  localparam logic [ACC_W:0]   c_sat_lim = (ACC_W+1)'((2**OUT_W) - 1);
  localparam logic [c_aw:0]    c_depth   = (c_aw+1)'(DEPTH);
  localparam logic [7:0]       c_drop_max = 8'hFF;

  // Stage 1: round-half-up and shift, one extra bit so the add cannot wrap
  logic [ACC_W:0]   w_sum;
  logic [ACC_W:0]   w_rnd;
  logic             r_s1_v;
  logic [ACC_W:0]   r_s1_r;

  assign w_sum = {1'b0, acc_in} + c_half;
  assign w_rnd = w_sum >> SHIFT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s1_r <= '0;
    end else begin
      r_s1_v <= sample;
      if (sample) begin
        r_s1_r <= w_rnd;
      end
    end
  end

  // Stage 2: saturate and push into the FIFO
  logic             w_over;
  logic [OUT_W-1:0] w_q;
  logic             w_sat_ev;
  logic             w_pop;
  logic             w_accept;
  logic             w_drop_ev;

  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic [OUT_W-1:0] r_last;
  logic             r_sat;
  logic [7:0]       r_drop;

  assign w_over    = (r_s1_r > c_sat_lim);
  assign w_q       = w_over ? {OUT_W{1'b1}} : r_s1_r[OUT_W-1:0];
  assign w_sat_ev  = r_s1_v && w_over;
  assign w_pop     = (r_count != '0) && out_ready;
  // A full FIFO still accepts when the head leaves on the same edge
  assign w_accept  = r_s1_v && ((r_count != c_depth) || w_pop);
  assign w_drop_ev = r_s1_v && !w_accept;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= w_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky status: a same-edge event takes priority over the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat  <= 1'b0;
      r_drop <= '0;
    end else begin
      if (w_sat_ev) begin
        r_sat <= 1'b1;
      end else if (clr_flags) begin
        r_sat <= 1'b0;
      end
      if (w_drop_ev) begin
        if (clr_flags) begin
          r_drop <= 8'd1;
        end else if (r_drop != c_drop_max) begin
          r_drop <= r_drop + 8'd1;
        end
      end else if (clr_flags) begin
        r_drop <= '0;
      end
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : r_last;
  assign fifo_full = (r_count == c_depth);
  assign sat_flag  = r_sat;
  assign drop_cnt  = r_drop;

endmodule
`default_nettype wire
